// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow, asynchronous
// clock-like input in clk_in cycles. Reports every completed rising-to-rising
// period with a one-cycle valid pulse. Also provides a lock flag (two equal
// measurements in a row) and a timeout for an input that has stopped toggling.

module clk_period_meter #(
  parameter int CNT_W = 28
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s1;
  logic             s2;
  logic             s2_d;
  // Marks which synchroniser stages hold real samples rather than reset values.
  logic [1:0]       sync_fill;
  logic             rise;
  state_t           state;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic             have_prev;

  assign rise = s2 & ~s2_d;

  // Resynchronise sig_in and keep one delayed copy for edge detection.
  always_ff @(posedge clk_in or posedge rst) begin
    // NOTE: nonblocking assignments make every stage load the old value of the
    // stage before it, which is what turns these lines into a shift chain.
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s2_d      <= 1'b0;
      sync_fill <= 2'b00;
    end else begin
      s1        <= sig_in;
      s2        <= s1;
      s2_d      <= s2;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // Measurement state machine. All results are registered here.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
      have_prev  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        // Wait for a genuine low level. The synchroniser's reset zeros do not
        // count, so an input already high at reset release is not mistaken
        // for a rising edge.
        IDLE: begin
          if (sync_fill[1] && !s2) begin
            state <= ARM;
          end
        end

        // The first rise only starts the count. There is no full period yet.
        ARM: begin
          if (rise) begin
            per_cnt <= CNT_ONE;
            hi_cnt  <= CNT_ONE;
            timeout <= 1'b0;
            state   <= MEASURE;
          end
        end

        MEASURE: begin
          if (rise) begin
            // A rise wins over saturation. A full-scale period is still reported.
            period     <= per_cnt;
            high_time  <= hi_cnt;
            meas_valid <= 1'b1;
            locked     <= have_prev & (per_cnt == period) & (hi_cnt == high_time);
            have_prev  <= 1'b1;
            per_cnt    <= CNT_ONE;
            hi_cnt     <= CNT_ONE;
          end else if (per_cnt == CNT_MAX) begin
            // The input has stalled. Keep the last results and start over.
            timeout   <= 1'b1;
            locked    <= 1'b0;
            have_prev <= 1'b0;
            state     <= IDLE;
          end else begin
            per_cnt <= per_cnt + CNT_ONE;
            if (s2 && hi_cnt != CNT_MAX) begin
              hi_cnt <= hi_cnt + CNT_ONE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
